// File: rtl/bpi_cfg_seq.sv
// Configuration-block sequencer for a BPI PROM engine: uploads four config
// words from PROM (UL) or erases and reprograms them from CFG_IN (DL).
module bpi_cfg_seq #(
  parameter logic [15:0] OP_LOAD_ADDR = 16'h0017,
  parameter logic [15:0] CFG_ADDR_HI  = 16'h007F,
  parameter logic [15:0] CFG_ADDR_LO  = 16'h0000,
  parameter logic [15:0] OP_READ4     = 16'h0064,
  parameter logic [15:0] OP_UNLOCK    = 16'h0014,
  parameter logic [15:0] OP_ERASE     = 16'h000A,
  parameter logic [15:0] OP_PROG4     = 16'h006C,
  parameter logic [23:0] TIMEOUT      = 24'd4000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        UL_REQ,
  input  logic        DL_REQ,
  input  logic [15:0] CFG_IN0,
  input  logic [15:0] CFG_IN1,
  input  logic [15:0] CFG_IN2,
  input  logic [15:0] CFG_IN3,
  output logic [15:0] CMD_DATA,
  output logic        CMD_WE,
  input  logic        CMD_FULL,
  input  logic [15:0] RBK_DATA,
  input  logic        RBK_EMPTY,
  output logic        RBK_RE,
  input  logic        PROM_BUSY,
  output logic [15:0] CFG_OUT0,
  output logic [15:0] CFG_OUT1,
  output logic [15:0] CFG_OUT2,
  output logic [15:0] CFG_OUT3,
  output logic        CFG_VALID,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  typedef enum logic [2:0] {
    IDLE, FLUSH, ISSUE, RBK, WAIT_PROM, FIN, FAIL
  } state_t;

  state_t            state_q, state_d;
  logic              dl_q, dl_d;
  logic [3:0]        idx_q, idx_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic [23:0]       tmo_q, tmo_d;
  logic              armed_q, armed_d;
  logic [3:0][15:0]  shadow_q, shadow_d;
  logic [3:0][15:0]  cfg_q, cfg_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              tmo_hit;
  logic [3:0]        last_idx;

  // Command word at position idx of the UL (4-word) or DL (13-word) sequence.
  function automatic logic [15:0] seq_word(input logic dl, input logic [3:0] idx,
                                           input logic [3:0][15:0] sh);
    logic [15:0] w;
    w = '0;
    if (!dl) begin
      case (idx[1:0])
        2'd0:    w = OP_LOAD_ADDR;
        2'd1:    w = CFG_ADDR_HI;
        2'd2:    w = CFG_ADDR_LO;
        default: w = OP_READ4;
      endcase
    end else begin
      case (idx)
        4'd0, 4'd5: w = OP_LOAD_ADDR;
        4'd1, 4'd6: w = CFG_ADDR_HI;
        4'd2, 4'd7: w = CFG_ADDR_LO;
        4'd3:       w = OP_UNLOCK;
        4'd4:       w = OP_ERASE;
        4'd8:       w = OP_PROG4;
        4'd9:       w = sh[0];
        4'd10:      w = sh[1];
        4'd11:      w = sh[2];
        4'd12:      w = sh[3];
        default:    w = '0;
      endcase
    end
    return w;
  endfunction

  assign tmo_hit  = (tmo_q == TIMEOUT - 24'd1);
  assign last_idx = dl_q ? 4'd12 : 4'd3;

  always_comb begin
    state_d  = state_q;
    dl_d     = dl_q;
    idx_d    = idx_q;
    wcnt_d   = wcnt_q;
    tmo_d    = tmo_q;
    armed_d  = armed_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    valid_d  = valid_q;
    err_d    = err_q;
    CMD_DATA = '0;
    CMD_WE   = 1'b0;
    RBK_RE   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (UL_REQ) begin
          err_d   = 1'b0;
          valid_d = 1'b0;
          dl_d    = 1'b0;
          idx_d   = '0;
          state_d = FLUSH;
        end else if (DL_REQ) begin
          err_d    = 1'b0;
          dl_d     = 1'b1;
          idx_d    = '0;
          shadow_d = {CFG_IN3, CFG_IN2, CFG_IN1, CFG_IN0};
          state_d  = ISSUE;
        end
      end
      FLUSH: begin
        if (RBK_EMPTY) state_d = ISSUE;
        else           RBK_RE  = 1'b1;
      end
      ISSUE: begin
        CMD_DATA = seq_word(dl_q, idx_q, shadow_q);
        if (!CMD_FULL) begin
          CMD_WE = 1'b1;
          idx_d  = idx_q + 4'd1;
          if (idx_q == last_idx) begin
            idx_d   = '0;
            tmo_d   = '0;
            wcnt_d  = '0;
            armed_d = 1'b0;
            state_d = dl_q ? WAIT_PROM : RBK;
          end
        end
      end
      RBK: begin
        tmo_d = tmo_q + 24'd1;
        if (!RBK_EMPTY) begin
          RBK_RE         = 1'b1;
          cfg_d[wcnt_q]  = RBK_DATA;
          wcnt_d         = wcnt_q + 2'd1;
        end
        // Capturing the fourth word takes precedence over an expiring timer.
        if (!RBK_EMPTY && wcnt_q == 2'd3) begin
          valid_d = 1'b1;
          state_d = FIN;
        end else if (tmo_hit) begin
          state_d = FAIL;
        end
      end
      WAIT_PROM: begin
        tmo_d = tmo_q + 24'd1;
        if (PROM_BUSY) armed_d = 1'b1;
        if (armed_q && !PROM_BUSY) begin
          cfg_d   = shadow_q;
          valid_d = 1'b1;
          state_d = FIN;
        end else if (tmo_hit) begin
          state_d = FAIL;
        end
      end
      FIN:  state_d = IDLE;
      FAIL: begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      dl_q     <= 1'b0;
      idx_q    <= '0;
      wcnt_q   <= '0;
      tmo_q    <= '0;
      armed_q  <= 1'b0;
      shadow_q <= '0;
      cfg_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dl_q     <= dl_d;
      idx_q    <= idx_d;
      wcnt_q   <= wcnt_d;
      tmo_q    <= tmo_d;
      armed_q  <= armed_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign CFG_OUT0  = cfg_q[0];
  assign CFG_OUT1  = cfg_q[1];
  assign CFG_OUT2  = cfg_q[2];
  assign CFG_OUT3  = cfg_q[3];
  assign CFG_VALID = valid_q;
  assign BUSY      = (state_q != IDLE);
  assign DONE      = (state_q == FIN);
  assign ERR       = err_q;

endmodule

// File: tb/tb_bpi_cfg_seq.sv
// Scoreboard bench for bpi_cfg_seq: stimulus pushes expected command words and
// outcomes; a negedge monitor pops and compares them as the DUT produces them.
module tb_bpi_cfg_seq;

  localparam logic [15:0] W_LOAD = 16'h0017, W_HI = 16'h007F, W_LO = 16'h0000,
                          W_RD4 = 16'h0064, W_UNL = 16'h0014, W_ERS = 16'h000A,
                          W_PRG = 16'h006C;

  logic        CLK = 1'b0;
  logic        RST, UL_REQ, DL_REQ;
  logic [15:0] CFG_IN0, CFG_IN1, CFG_IN2, CFG_IN3;
  logic [15:0] CMD_DATA;
  logic        CMD_WE, CMD_FULL;
  logic [15:0] RBK_DATA;
  logic        RBK_EMPTY, RBK_RE, PROM_BUSY;
  logic [15:0] CFG_OUT0, CFG_OUT1, CFG_OUT2, CFG_OUT3;
  logic        CFG_VALID, BUSY, DONE, ERR;

  always #5 CLK = ~CLK;

  bpi_cfg_seq #(.TIMEOUT(24'd100)) dut (
    .CLK(CLK), .RST(RST), .UL_REQ(UL_REQ), .DL_REQ(DL_REQ),
    .CFG_IN0(CFG_IN0), .CFG_IN1(CFG_IN1), .CFG_IN2(CFG_IN2), .CFG_IN3(CFG_IN3),
    .CMD_DATA(CMD_DATA), .CMD_WE(CMD_WE), .CMD_FULL(CMD_FULL),
    .RBK_DATA(RBK_DATA), .RBK_EMPTY(RBK_EMPTY), .RBK_RE(RBK_RE),
    .PROM_BUSY(PROM_BUSY),
    .CFG_OUT0(CFG_OUT0), .CFG_OUT1(CFG_OUT1), .CFG_OUT2(CFG_OUT2), .CFG_OUT3(CFG_OUT3),
    .CFG_VALID(CFG_VALID), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  typedef struct packed { logic [1:0] tag; logic [15:0] w; } cmd_t;      // tag 1: READ4, 2: last DL word
  typedef struct packed { logic fail; logic [63:0] cfg; logic valid; } res_t;

  cmd_t        cmd_q[$];
  res_t        res_q[$];
  int          wr_cyc[$];
  int          checks = 0, passes = 0;
  int          cyc = 0, wr_cnt = 0, pop_cnt = 0, read4_cnt = 0, prog_cnt = 0;
  int          last_wr_cyc = 0, err_cyc = 0;
  logic        pop_pend = 1'b0, prev_done = 1'b0, prev_err = 1'b0;

  // Environment state, owned by the stimulus process.
  logic [15:0] rfifo[$], prom_pend[$];
  logic [15:0] prom_words[4];
  int          r4_done = 0, pg_done = 0, busy_wait = 0, busy_len = 0;
  int          full_pct = 0, full_force = 0;
  bit          no_busy = 0;
  logic [63:0] model_cfg = '0;
  logic        model_valid = 1'b0;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endfunction

  // Monitor / scoreboard checker.
  initial forever begin
    cmd_t c;
    res_t r;
    @(negedge CLK);
    cyc++;
    if (CMD_WE === 1'b1) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      wr_cyc.push_back(cyc);
      chk("we_while_full", 64'(CMD_FULL), 64'(0));
      chk("we_with_re", 64'(RBK_RE), 64'(0));
      chk("write_expected", 64'(cmd_q.size() > 0), 64'(1));
      if (cmd_q.size() > 0) begin
        c = cmd_q.pop_front();
        chk("cmd_word", 64'(CMD_DATA), 64'(c.w));
        if (c.tag == 2'd1) read4_cnt++;
        if (c.tag == 2'd2) prog_cnt++;
      end
    end
    if (RBK_RE === 1'b1) pop_cnt++;
    pop_pend = (RBK_RE === 1'b1);
    if (DONE === 1'b1) begin
      chk("done_one_cycle", 64'(prev_done), 64'(0));
      chk("done_expected", 64'(res_q.size() > 0), 64'(1));
      if (res_q.size() > 0) begin
        r = res_q.pop_front();
        chk("done_kind", 64'(r.fail), 64'(0));
        chk("cfg_out", {CFG_OUT3, CFG_OUT2, CFG_OUT1, CFG_OUT0}, r.cfg);
        chk("cfg_valid", 64'(CFG_VALID), 64'(1));
        chk("err_low_on_done", 64'(ERR), 64'(0));
      end
    end
    if (ERR === 1'b1 && prev_err !== 1'b1) begin
      err_cyc = cyc;
      chk("err_expected", 64'(res_q.size() > 0), 64'(1));
      if (res_q.size() > 0) begin
        r = res_q.pop_front();
        chk("err_kind", 64'(r.fail), 64'(1));
        chk("cfg_out_after_fail", {CFG_OUT3, CFG_OUT2, CFG_OUT1, CFG_OUT0}, r.cfg);
        chk("cfg_valid_after_fail", 64'(CFG_VALID), 64'(r.valid));
      end
    end
    prev_done = DONE;
    prev_err  = ERR;
  end

  // Advance one cycle; model readback FIFO, PROM responses and command FIFO fullness.
  task automatic step();
    @(posedge CLK);
    #1;
    if (pop_pend && rfifo.size() > 0) void'(rfifo.pop_front());
    if (read4_cnt > r4_done) begin
      r4_done = read4_cnt;
      for (int i = 0; i < 4; i++) prom_pend.push_back(prom_words[i]);
    end
    if (prom_pend.size() > 0 && $urandom_range(0, 1) == 1) rfifo.push_back(prom_pend.pop_front());
    if (prog_cnt > pg_done) begin
      pg_done = prog_cnt;
      if (!no_busy) begin
        busy_wait = $urandom_range(0, 5);
        busy_len  = $urandom_range(1, 30);
      end
    end
    if (busy_wait > 0) begin busy_wait--; PROM_BUSY = 1'b0; end
    else if (busy_len > 0) begin busy_len--; PROM_BUSY = 1'b1; end
    else PROM_BUSY = 1'b0;
    RBK_EMPTY = (rfifo.size() == 0);
    RBK_DATA  = (rfifo.size() > 0) ? rfifo[0] : 16'hDEAD;
    if (full_force > 0) begin full_force--; CMD_FULL = 1'b1; end
    else CMD_FULL = ($urandom_range(0, 99) < full_pct);
  endtask

  task automatic apply_reset(input bit with_req);
    RST = 1'b1; UL_REQ = with_req; DL_REQ = with_req;
    step();
    RST = 1'b0; UL_REQ = 1'b0; DL_REQ = 1'b0;
    cmd_q.delete(); res_q.delete(); rfifo.delete(); prom_pend.delete();
    busy_wait = 0; busy_len = 0; PROM_BUSY = 1'b0; RBK_EMPTY = 1'b1; RBK_DATA = 16'hDEAD;
    model_cfg = '0; model_valid = 1'b0;
    chk("rst_ctrl", 64'({CMD_WE, RBK_RE, CFG_VALID, BUSY, DONE, ERR}), 64'(0));
    chk("rst_cmd_data", 64'(CMD_DATA), 64'(0));
    chk("rst_cfg_out", {CFG_OUT3, CFG_OUT2, CFG_OUT1, CFG_OUT0}, 64'(0));
  endtask

  task automatic do_ul(input logic [63:0] words, input bit both);
    for (int i = 0; i < 4; i++) prom_words[i] = words[16*i +: 16];
    cmd_q.push_back({2'd0, W_LOAD});
    cmd_q.push_back({2'd0, W_HI});
    cmd_q.push_back({2'd0, W_LO});
    cmd_q.push_back({2'd1, W_RD4});
    model_cfg = words; model_valid = 1'b1;
    res_q.push_back({1'b0, words, 1'b1});
    UL_REQ = 1'b1; DL_REQ = both;
    step();
    UL_REQ = 1'b0; DL_REQ = 1'b0;
    chk("busy_after_ul", 64'(BUSY), 64'(1));
  endtask

  task automatic do_dl(input logic [63:0] vals, input bit tmo);
    logic [15:0] seq[13];
    seq = '{W_LOAD, W_HI, W_LO, W_UNL, W_ERS, W_LOAD, W_HI, W_LO, W_PRG,
            vals[15:0], vals[31:16], vals[47:32], vals[63:48]};
    for (int i = 0; i < 13; i++) cmd_q.push_back({(i == 12) ? 2'd2 : 2'd0, seq[i]});
    if (!tmo) begin
      model_cfg = vals; model_valid = 1'b1;
      res_q.push_back({1'b0, vals, 1'b1});
    end else begin
      res_q.push_back({1'b1, model_cfg, model_valid});
    end
    no_busy = tmo;
    {CFG_IN3, CFG_IN2, CFG_IN1, CFG_IN0} = vals;
    DL_REQ = 1'b1;
    step();
    DL_REQ = 1'b0;
    {CFG_IN3, CFG_IN2, CFG_IN1, CFG_IN0} = {$urandom, $urandom};
    chk("busy_after_dl", 64'(BUSY), 64'(1));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (res_q.size() > 0 && n < budget) begin step(); n++; end
    chk("outcome_within_budget", 64'(res_q.size()), 64'(0));
    chk("cmd_q_drained", 64'(cmd_q.size()), 64'(0));
    if (res_q.size() > 0) apply_reset(1'b0);
    else chk("idle_after_outcome", 64'(BUSY), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int w0, p0, b;
    logic [63:0] v;
    RST = 1'b1; UL_REQ = 1'b0; DL_REQ = 1'b0;
    {CFG_IN3, CFG_IN2, CFG_IN1, CFG_IN0} = '0;
    CMD_FULL = 1'b0; RBK_EMPTY = 1'b1; RBK_DATA = 16'hDEAD; PROM_BUSY = 1'b0;
    step();
    apply_reset(1'b1);

    // Plain upload, FIFO never full.
    full_pct = 0;
    b = wr_cyc.size();
    do_ul(64'h4444_3333_2222_1111, 1'b0);
    wait_idle(300);
    chk("ul_back_to_back", 64'(wr_cyc[b+3] - wr_cyc[b]), 64'(3));

    // Download with snapshot and five full cycles at word 6.
    w0 = wr_cnt;
    do_dl(64'h0003_0002_0001_A5A5, 1'b0);
    for (int n = 0; n < 100 && (wr_cnt - w0) < 6; n++) step();
    chk("reach_word6", 64'(wr_cnt - w0), 64'(6));
    CMD_FULL = 1'b1; full_force = 4;
    for (int n = 0; n < 4; n++) step();
    chk("held_while_full", 64'(wr_cnt - w0), 64'(6));
    wait_idle(300);
    chk("dl_write_count", 64'(wr_cnt - w0), 64'(13));

    // Upload with stale readback words to flush.
    rfifo.push_back(16'hBAD0); rfifo.push_back(16'hBAD1); rfifo.push_back(16'hBAD2);
    RBK_EMPTY = 1'b0; RBK_DATA = rfifo[0];
    p0 = pop_cnt; w0 = wr_cnt;
    do_ul({$urandom, $urandom}, 1'b0);
    for (int n = 0; n < 100 && wr_cnt == w0; n++) step();
    chk("flush_pops", 64'(pop_cnt - p0), 64'(3));
    wait_idle(300);

    // Simultaneous UL+DL, then DL during busy: only the upload runs.
    do_ul({$urandom, $urandom}, 1'b1);
    step();
    DL_REQ = 1'b1; step(); DL_REQ = 1'b0;
    wait_idle(300);

    // Download with PROM never busy: timeout, then a fresh upload clears ERR.
    do_dl({$urandom, $urandom}, 1'b1);
    wait_idle(400);
    chk("timeout_latency", 64'(err_cyc - last_wr_cyc), 64'(102));
    chk("err_sticky", 64'(ERR), 64'(1));
    step();
    chk("err_still_sticky", 64'(ERR), 64'(1));
    do_ul({$urandom, $urandom}, 1'b0);
    chk("err_cleared_on_accept", 64'(ERR), 64'(0));
    wait_idle(300);

    // Reset mid-download at word 7, with a request in the reset cycle.
    full_pct = 0;
    w0 = wr_cnt;
    do_dl({$urandom, $urandom}, 1'b0);
    for (int n = 0; n < 100 && (wr_cnt - w0) < 7; n++) step();
    chk("reach_word7", 64'(wr_cnt - w0), 64'(7));
    apply_reset(1'b1);
    do_ul({$urandom, $urandom}, 1'b0);
    wait_idle(300);

    // Randomised mix.
    for (int t = 0; t < 16; t++) begin
      full_pct = $urandom_range(0, 40);
      v = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0: do_dl(v, 1'b0);
        1: begin
          do_ul(v, 1'b0);
          DL_REQ = 1'b1; step(); DL_REQ = 1'b0;
        end
        default: begin
          for (int s = 0; s < int'($urandom_range(1, 3)); s++) rfifo.push_back(16'(s + 16'hE000));
          RBK_EMPTY = 1'b0; RBK_DATA = rfifo[0];
          do_ul(v, 1'b0);
        end
      endcase
      wait_idle(600);
    end

    chk("final_cmd_q_empty", 64'(cmd_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bpi_cfg_seq.md
BPI_CFG_SEQ -- requirements
Module: bpi_cfg_seq

Interface
REQ-001 Parameter OP_LOAD_ADDR, 16'h0017, BPI command word that loads the PROM address.
REQ-002 Parameter CFG_ADDR_HI, 16'h007F, upper PROM address word of the configuration block.
REQ-003 Parameter CFG_ADDR_LO, 16'h0000, lower PROM address word of the configuration block.
REQ-004 Parameter OP_READ4, 16'h0064, BPI command word for "read 4 words".
REQ-005 Parameter OP_UNLOCK, 16'h0014, block unlock command word.
REQ-006 Parameter OP_ERASE, 16'h000A, block erase command word.
REQ-007 Parameter OP_PROG4, 16'h006C, BPI command word for "program 4 words".
REQ-008 Parameter TIMEOUT, 24'd4000000, wait-state cycle limit (100 ms at 40 MHz).
REQ-009 Ports:
- CLK, in, 1: 40 MHz clock; one clock only.
- RST, in, 1: reset, synchronous and active-high.
- UL_REQ, in, 1: upload pulse (PROM to registers).
- DL_REQ, in, 1: download pulse (registers to PROM).
- CFG_IN0..CFG_IN3, in, 16 each: values to program.
- CMD_DATA, out, 16: command FIFO write data.
- CMD_WE, out, 1: command FIFO write enable.
- CMD_FULL, in, 1: command FIFO full.
- RBK_DATA, in, 16: readback FIFO head word (first-word-fall-through).
- RBK_EMPTY, in, 1: readback FIFO empty.
- RBK_RE, out, 1: readback FIFO pop.
- PROM_BUSY, in, 1: BPI engine executing.
- CFG_OUT0..CFG_OUT3, out, 16 each: configuration register images.
- CFG_VALID, out, 1: CFG_OUT holds PROM-consistent data.
- BUSY, out, 1: sequence in progress.
- DONE, out, 1: one-cycle completion pulse.
- ERR, out, 1: sticky timeout flag.

Function
REQ-010 States SHALL be IDLE, FLUSH, ISSUE, RBK, WAIT_PROM, FIN, FAIL; BUSY=1 in every state except IDLE.
REQ-011 In IDLE, UL_REQ SHALL be accepted, taking priority over DL_REQ; a DL_REQ in the same cycle is dropped.
REQ-012 Requests in any state other than IDLE SHALL be ignored, with no queuing.
REQ-013 On accept, ERR SHALL clear.
- UL: CFG_VALID clears; next state FLUSH.
- DL: CFG_IN0..3 are snapshotted into internal shadow registers; next state ISSUE.
REQ-014 FLUSH SHALL assert RBK_RE every cycle RBK_EMPTY=0, discarding the data, and go to ISSUE on the first cycle RBK_EMPTY=1.
REQ-015 ISSUE SHALL present the sequence word at the current index on CMD_DATA, with CMD_WE=1 only when CMD_FULL=0; the index advances only on a write.
- CMD_FULL=1: CMD_WE=0 and the word is held.
- Throughput: one word per cycle.
REQ-016 The UL sequence SHALL be 4 words: OP_LOAD_ADDR, CFG_ADDR_HI, CFG_ADDR_LO, OP_READ4; after the last write go to RBK.
REQ-017 The DL sequence SHALL be 13 words, in order:
- OP_LOAD_ADDR, CFG_ADDR_HI, CFG_ADDR_LO, OP_UNLOCK, OP_ERASE
- OP_LOAD_ADDR, CFG_ADDR_HI, CFG_ADDR_LO, OP_PROG4
- shadow0, shadow1, shadow2, shadow3
- After the last write go to WAIT_PROM.
REQ-018 RBK SHALL assert RBK_RE in each cycle RBK_EMPTY=0 and capture RBK_DATA into CFG_OUT[k] in that same cycle, k=0..3 in order; after k=3 go to FIN with CFG_VALID set.
REQ-019 WAIT_PROM SHALL first wait for PROM_BUSY=1 (arm), then for PROM_BUSY=0; it then copies the shadows into CFG_OUT0..3, sets CFG_VALID and goes to FIN.
REQ-020 A 24-bit timeout counter SHALL clear on entry to RBK or WAIT_PROM and increment each cycle in those states.
- Reaching TIMEOUT-1 goes to FAIL.
- When completion and timeout occur in the same cycle, completion wins.
REQ-021 FIN SHALL assert DONE for exactly one cycle, then return to IDLE.
REQ-022 FAIL SHALL set ERR and return to IDLE next cycle.
- ERR holds until the next accepted request or reset.
- CFG_OUT is unchanged; CFG_VALID stays 0 for a failed UL and keeps its prior value for a failed DL.
REQ-023 CMD_WE and RBK_RE SHALL never be asserted in the same cycle, and never in IDLE, FIN or FAIL.

Reset
REQ-024 RST, sampled on the CLK edge, SHALL return the state to IDLE from any state, including mid-sequence. Reset values:
- CMD_WE=0, RBK_RE=0, CMD_DATA=0
- CFG_OUT0..3=0, CFG_VALID=0
- BUSY=0, DONE=0, ERR=0
- Index, word counter, timeout counter and shadows=0
REQ-025 A request asserted in the same cycle as RST SHALL be ignored.

Verification
REQ-026 UL, FIFO never full, RBK_EMPTY=1 at start, PROM returns 1111,2222,3333,4444 -> exactly 4 writes (0017,007F,0000,0064) on consecutive cycles; CFG_OUT0..3=1111..4444; CFG_VALID=1; DONE one cycle.
REQ-027 DL with CFG_IN=A5A5,0001,0002,0003; CFG_IN changes after accept; CMD_FULL high for 5 cycles at word 6 -> 13 writes in REQ-017 order using the snapshot values; no write while full; DONE after PROM_BUSY 1->0.
REQ-028 UL with 3 stale words in the readback FIFO -> 3 pops in FLUSH before the first CMD_WE; captured values exclude the stale words.
REQ-029 DL with PROM_BUSY never rising (TIMEOUT=100 override) -> FAIL after 100 cycles in WAIT_PROM; ERR=1; no DONE; next UL accept clears ERR.
REQ-030 UL_REQ and DL_REQ in the same cycle -> UL runs and DL is dropped; DL_REQ during BUSY is ignored.
REQ-031 RST at ISSUE word 7 of a DL -> the next cycle has all outputs at reset values and IDLE; a subsequent UL runs normally.
